// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: four-state ALU sequencer that reads two registers, computes, and writes back to an 8x8 register file.
module rf_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] RX,
  output logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] busX,
  input  logic [DATA_W-1:0] busY,
  output logic              WEN,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] busW,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_zero
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q, op_a, op_b;
  logic [DATA_W:0]   alu, shr;
  // Bit DATA_W of alu carries the carry/borrow; shifts pad one extra bit to catch the last bit out
  assign shr = {op_a, 1'b0} >> op_b[2:0];
  always_comb begin
    alu = '0;
    case (op_q)
      3'd0: alu = {1'b0, op_a} + {1'b0, op_b};
      3'd1: alu = {1'b0, op_a} - {1'b0, op_b};
      3'd2: alu = {1'b0, op_a & op_b};
      3'd3: alu = {1'b0, op_a | op_b};
      3'd4: alu = {1'b0, op_a ^ op_b};
      3'd5: alu = {1'b0, op_a} << op_b[2:0];
      3'd6: alu = {shr[0], shr[DATA_W:1]};
      3'd7: alu = {1'b0, imm_q};
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      WEN       <= 1'b0;
      out_valid <= 1'b0;
      RX        <= '0;
      RY        <= '0;
      RW        <= '0;
      busW      <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state    <= READ;
          in_ready <= 1'b0;
          op_q     <= op;
          rd_q     <= rd;
          imm_q    <= imm;
          RX       <= rs;
          RY       <= rt;
        end
        READ: begin
          op_a  <= busX;
          op_b  <= busY;
          state <= EXEC;
        end
        EXEC: begin
          state     <= WRITE;
          WEN       <= rd_q != '0;
          RW        <= rd_q;
          busW      <= alu[DATA_W-1:0];
          out_data  <= alu[DATA_W-1:0];
          out_carry <= alu[DATA_W];
          out_zero  <= alu[DATA_W-1:0] == '0;
          out_valid <= 1'b1;
        end
        WRITE: begin
          state     <= IDLE;
          WEN       <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: directed checks of rf_op_sequencer against a behavioural 8x8 register file.
module tb_rf_op_sequencer;
  logic       Clk = 1'b0, Reset = 1'b1, in_valid = 1'b0, clr = 1'b1;
  logic       in_ready, WEN, out_valid, out_carry, out_zero;
  logic [2:0] op = '0, rd = '0, rs = '0, rt = '0, RX, RY, RW;
  logic [7:0] imm = '0, busX, busY, busW, out_data;
  logic [7:0] rf [8];
  int checks = 0, failures = 0;

  rf_op_sequencer dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .WEN(WEN), .RW(RW), .busW(busW),
    .out_valid(out_valid), .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
  );

  always #5 Clk = ~Clk;

  // r0 keeps real storage so a stray write to it stays visible; reads of r0 return zero
  assign busX = RX == 3'd0 ? 8'd0 : rf[RX];
  assign busY = RY == 3'd0 ? 8'd0 : rf[RY];
  always @(posedge Clk) begin
    if (clr) rf <= '{default: 8'd0};
    else if (WEN) rf[RW] <= busW;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] d, s, t,
                        input logic [7:0] im, input logic [7:0] ed, input logic ec, ez);
    int lat = 0, nv = 0, nw = 0, nr = 0;
    logic [7:0] gd = '0;
    logic gc = 1'b0, gz = 1'b0, wok = 1'b1;
    @(negedge Clk);
    op = o; rd = d; rs = s; rt = t; imm = im; in_valid = 1'b1;
    chk({tag, ".ready"}, in_ready, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (k == 1) in_valid = 1'b0;
      if (k <= 3 && !in_ready) nr++;
      if (WEN) begin
        nw++;
        if (RW != d || busW != ed) wok = 1'b0;
      end
      if (out_valid) begin
        nv++;
        if (lat == 0) lat = k;
        gd = out_data; gc = out_carry; gz = out_zero;
      end
    end
    chk({tag, ".latency"}, lat, 3);
    chk({tag, ".valid_cycles"}, nv, 1);
    chk({tag, ".wen_cycles"}, nw, d != 3'd0 ? 1 : 0);
    chk({tag, ".busy_cycles"}, nr, 3);
    chk({tag, ".write_port"}, wok, 1);
    chk({tag, ".data"}, gd, ed);
    chk({tag, ".carry"}, gc, ec);
    chk({tag, ".zero"}, gz, ez);
  endtask

  initial begin
    int acc = 0, nv = 0;
    repeat (3) @(negedge Clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.wen", WEN, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.rx_ry_rw", {RX, RY, RW}, 0);
    chk("rst.busw", busW, 0);
    chk("rst.out", {out_data, out_carry, out_zero}, 0);
    Reset = 1'b0; clr = 1'b0;

    run_op("movi_r1", 3'd7, 3'd1, 3'd0, 3'd0, 8'd100, 8'd100, 1'b0, 1'b0);
    run_op("movi_r2", 3'd7, 3'd2, 3'd5, 3'd6, 8'd50, 8'd50, 1'b0, 1'b0);
    chk("rf.r1", rf[1], 100);
    chk("rf.r2", rf[2], 50);
    run_op("add_r3", 3'd0, 3'd3, 3'd1, 3'd2, 8'd0, 8'd150, 1'b0, 1'b0);
    chk("rf.r3", rf[3], 150);
    run_op("add_r4", 3'd0, 3'd4, 3'd3, 3'd3, 8'd0, 8'd44, 1'b1, 1'b0);
    run_op("sub_r5", 3'd1, 3'd5, 3'd2, 3'd1, 8'd0, 8'd206, 1'b1, 1'b0);
    run_op("sub_r6", 3'd1, 3'd6, 3'd1, 3'd1, 8'd0, 8'd0, 1'b0, 1'b1);
    run_op("movi_r0", 3'd7, 3'd0, 3'd0, 3'd0, 8'd255, 8'd255, 1'b0, 1'b0);
    chk("rf.r0", rf[0], 0);
    run_op("movi_r6", 3'd7, 3'd6, 3'd0, 3'd0, 8'd3, 8'd3, 1'b0, 1'b0);
    run_op("shl_r7", 3'd5, 3'd7, 3'd2, 3'd6, 8'd0, 8'd144, 1'b1, 1'b0);
    chk("rf.r7", rf[7], 144);
    run_op("shr_r5", 3'd6, 3'd5, 3'd1, 3'd6, 8'd0, 8'd12, 1'b1, 1'b0);
    run_op("shl0_r4", 3'd5, 3'd4, 3'd1, 3'd0, 8'd0, 8'd100, 1'b0, 1'b0);
    run_op("and_r5", 3'd2, 3'd5, 3'd1, 3'd2, 8'd0, 8'd32, 1'b0, 1'b0);
    run_op("or_r5", 3'd3, 3'd5, 3'd1, 3'd2, 8'd0, 8'd118, 1'b0, 1'b0);
    run_op("xor_r4", 3'd4, 3'd4, 3'd1, 3'd2, 8'd0, 8'd86, 1'b0, 1'b0);
    chk("rf.r4", rf[4], 86);

    // reset lands on the edge closing EXEC of ADD r3 = r1 + r1
    @(negedge Clk);
    op = 3'd0; rd = 3'd3; rs = 3'd1; rt = 3'd1; in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst.in_ready", in_ready, 1);
    chk("midrst.wen", WEN, 0);
    chk("midrst.out_valid", out_valid, 0);
    nv = 0;
    repeat (4) begin
      @(negedge Clk);
      nv += (out_valid || WEN) ? 1 : 0;
    end
    chk("midrst.quiet", nv, 0);
    chk("midrst.r3", rf[3], 150);
    run_op("movi_after_rst", 3'd7, 3'd1, 3'd0, 3'd0, 8'd7, 8'd7, 1'b0, 1'b0);
    chk("rf.r1_after_rst", rf[1], 7);

    // a continuously valid source is accepted once every four cycles
    @(negedge Clk);
    op = 3'd7; rd = 3'd2; imm = 8'd9; in_valid = 1'b1;
    acc = 0; nv = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge Clk);
      acc += in_ready ? 1 : 0;
      nv += out_valid ? 1 : 0;
      if (in_ready && i % 4 != 0) chk($sformatf("hold.ready_at_%0d", i), in_ready, 0);
    end
    in_valid = 1'b0;
    chk("hold.accepts", acc, 5);
    chk("hold.results", nv, 5);
    repeat (2) @(negedge Clk);
    chk("hold.idle", in_ready, 1);
    chk("hold.r2", rf[2], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
